// File: rtl/strobe_to_handshake_tx.sv
// strobe_to_handshake_tx
//
// Buffers single-cycle byte strobes from internal logic in a small FIFO and
// presents each byte to a slower or foreign consumer as a held level request
// closed by a four-phase req/ack handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (release expected synchronous)
//   strobe_in    single-cycle write strobe
//   data_in      byte sampled when strobe_in = 1
//   ack_in       consumer acknowledge, four-phase
//   trigger_out  level request, held until acknowledged
//   data_out     byte under request; 8'h00 while trigger_out = 0
//   full         FIFO holds DEPTH bytes
//   empty        FIFO holds no bytes
//   overflow     one-cycle pulse: strobe dropped because the FIFO was full
//   timeout      one-cycle pulse: request aborted without an ack
module strobe_to_handshake_tx #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned SYNC_ACK = 1,
    parameter int unsigned TIMEOUT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe_in,
    input  logic [7:0] data_in,
    input  logic       ack_in,
    output logic       trigger_out,
    output logic [7:0] data_out,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       timeout
);

    // The counter only has to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]  COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitAckLow
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q;
    logic              overflow_q;
    logic              timeout_q, timeout_d;
    logic              trig_q, trig_d;
    logic [7:0]        data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;
    logic              ack_s;

    // ------------------------------------------------------------------
    // Acknowledge path
    // ------------------------------------------------------------------
    if (SYNC_ACK != 0) begin : g_sync
        logic ack_meta_q, ack_sync_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ack_meta_q <= 1'b0;
                ack_sync_q <= 1'b0;
            end else begin
                ack_meta_q <= ack_in;
                ack_sync_q <= ack_meta_q;
            end
        end

        assign ack_s = ack_sync_q;
    end else begin : g_nosync
        assign ack_s = ack_in;
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Uses the registered full, so a same-edge pop never frees room.
    assign push = strobe_in & ~full_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            full_q     <= (count_d == COUNT_FULL);
            empty_q    <= (count_d == '0);
            overflow_q <= strobe_in & full_q;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        trig_d    = trig_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A high ack here is left over from the last transfer.
                if (!empty_q && !ack_s) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    trig_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ack_s) begin
                    trig_d  = 1'b0;
                    data_d  = 8'h00;
                    state_d = StWaitAckLow;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    // Aborted byte is discarded, not retried.
                    trig_d    = 1'b0;
                    data_d    = 8'h00;
                    timeout_d = 1'b1;
                    state_d   = StWaitAckLow;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitAckLow: begin
                if (!ack_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            trig_q    <= 1'b0;
            data_q    <= 8'h00;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            trig_q    <= trig_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign trigger_out = trig_q;
    assign data_out    = data_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign overflow    = overflow_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_strobe_to_handshake_tx.sv
// Directed bench for strobe_to_handshake_tx (DEPTH=4, SYNC_ACK=0, TIMEOUT=8).
// Accepted bytes are queued when strobed and compared when requested.
module tb_strobe_to_handshake_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       strobe_in;
    logic [7:0] data_in;
    logic       ack_in;
    logic       trigger_out;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       timeout;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    strobe_to_handshake_tx #(
        .DEPTH    (4),
        .ADDR_W   (2),
        .SYNC_ACK (0),
        .TIMEOUT  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .strobe_in   (strobe_in),
        .data_in     (data_in),
        .ack_in      (ack_in),
        .trigger_out (trigger_out),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit accept);
        strobe_in = 1'b1;
        data_in   = b;
        if (accept) sb.push_back(b);
        tick();
        strobe_in = 1'b0;
    endtask

    // Wait for a request, check its byte, hold for 'delay' cycles, then ack
    // for 'hold' cycles and release.
    task automatic consume(input int delay, input int hold);
        int         n = 0;
        logic [7:0] exp_b;
        while (trigger_out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", trigger_out, 1);
        exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk("req_data", data_out, exp_b);
        repeat (delay) begin
            tick();
            chk("req_hold", {trigger_out, data_out}, {1'b1, exp_b});
        end
        ack_in = 1'b1;
        tick();
        chk("ack_trig", trigger_out, 0);
        chk("ack_data", data_out, 0);
        repeat (hold - 1) tick();
        ack_in = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        strobe_in = 1'b0;
        ack_in    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
        tick();
    endtask

    initial begin
        int n;
        int tp;
        rst_n     = 1'b0;
        strobe_in = 1'b0;
        data_in   = 8'h00;
        ack_in    = 1'b0;
        tick();
        tick();
        chk("rst_outs", {trigger_out, data_out, full, empty, overflow, timeout},
            {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        rst_n = 1'b1;
        tick();

        // Reset asserted mid-request with strobe held high.
        send(8'h11, 1);
        tick();
        chk("pre_rst_trig", trigger_out, 1);
        strobe_in = 1'b1;
        data_in   = 8'h22;
        rst_n     = 1'b0;
        #1;
        chk("async_rst", {trigger_out, data_out, empty, full},
            {1'b1 & 1'b0, 8'h00, 1'b1, 1'b0});
        tick();
        chk("rst_hold", {trigger_out, data_out, empty}, {1'b0, 8'h00, 1'b1});
        strobe_in = 1'b0;
        sb.delete();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_idle", {trigger_out, empty}, {1'b0, 1'b1});

        // Single byte: latency, hold and release.
        send(8'hA5, 1);
        chk("lat_e0", trigger_out, 0);
        tick();
        chk("lat_e1", trigger_out, 1);
        consume(2, 2);
        tick();
        chk("single_idle", {trigger_out, data_out, empty}, {1'b0, 8'h00, 1'b1});

        // Burst of six strobes into a four-entry FIFO.
        send(8'h01, 1);
        send(8'h02, 1);
        send(8'h03, 1);
        send(8'h04, 1);
        chk("burst_full4", full, 0);
        send(8'h05, 1);
        chk("burst_full5", full, 1);
        send(8'h06, 0);
        chk("ovf_pulse", overflow, 1);
        tick();
        chk("ovf_clear", overflow, 0);
        repeat (5) consume(0, 1);
        chk("burst_empty", empty, 1);

        // Stale ack high at reset release.
        rst_n  = 1'b0;
        ack_in = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h77, 1);
        repeat (3) tick();
        chk("stale_notrig", trigger_out, 0);
        chk("stale_queued", empty, 0);
        ack_in = 1'b0;
        consume(0, 1);

        // Timeout: 3C aborted after 8 cycles, then 3D requested.
        send(8'h3C, 1);
        send(8'h3D, 1);
        chk("to_data", data_out, 8'h3C);
        n  = 0;
        tp = 0;
        while (trigger_out === 1'b1 && n < 20) begin
            tick();
            n++;
            if (timeout === 1'b1) tp++;
        end
        chk("to_hi_cycles", n, 8);
        chk("to_pulse", tp, 1);
        chk("to_data_low", data_out, 0);
        void'(sb.pop_front());
        tick();
        chk("to_pulse_end", {timeout, trigger_out}, {1'b0, 1'b0});
        consume(0, 1);
        chk("to_empty", empty, 1);

        // Simultaneous write/pop at count 2 across the write-pointer wrap.
        do_reset();
        send(8'hA0, 1);
        send(8'hB0, 1);
        send(8'hC0, 1);
        consume(0, 1);
        send(8'hD0, 1);
        chk("wrap_flags", {full, empty}, {1'b0, 1'b0});
        send(8'hE0, 1);
        chk("wrap_full3", full, 0);
        send(8'hF0, 1);
        chk("wrap_full4", full, 1);
        repeat (5) consume(0, 1);
        chk("wrap_empty", {empty, sb.size() == 0}, {1'b1, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
